// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with shadowed value, blanking and dead-cycle anti-ghosting.
// Optional decimal-point support is enabled by defining SEVEN_SEG_SCAN_DP_EN.
module seven_seg_scan #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    loadIn,
  input  logic [4*NUM_DIGITS-1:0] valueIn,
  input  logic [NUM_DIGITS-1:0]   blankIn,
  input  logic                    lzbIn,
`ifdef SEVEN_SEG_SCAN_DP_EN
  input  logic [NUM_DIGITS-1:0]   dpIn,
  output logic                    dpOut,
`endif
  output logic [6:0]              segOut,
  output logic [NUM_DIGITS-1:0]   digitOut,
  output logic                    scanTick
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;

  logic [VAL_W-1:0]      value_q, value_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  lzb_q, lzb_d;
  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  tick_q, tick_d;
`ifdef SEVEN_SEG_SCAN_DP_EN
  logic [NUM_DIGITS-1:0] dpm_q, dpm_d;
  logic                  dp_q, dp_d;
`endif

  // Active-low segment pattern for one hex nibble (bit0 = a ... bit6 = g)
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Shadow capture and slot divider / digit index advance
  always_comb begin
    value_d   = value_q;
    blank_d   = blank_q;
    lzb_d     = lzb_q;
    div_cnt_d = div_cnt_q + CNT_W'(1);
    idx_d     = idx_q;
`ifdef SEVEN_SEG_SCAN_DP_EN
    dpm_d     = dpm_q;
`endif
    if (loadIn) begin
      value_d = valueIn;
      blank_d = blankIn;
      lzb_d   = lzbIn;
`ifdef SEVEN_SEG_SCAN_DP_EN
      dpm_d   = dpIn;
`endif
    end
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Next registered outputs from the current slot state
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  lead_zero;
  logic [3:0]            nib;
  logic                  off;
  always_comb begin
    lz_mask   = '0;
    lead_zero = 1'b1;
    nib       = 4'h0;
    off       = 1'b0;
    dig_d     = '1;
`ifdef SEVEN_SEG_SCAN_DP_EN
    dp_d      = 1'b1;
`endif
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lead_zero  = lead_zero && (value_q[4*i +: 4] == 4'h0);
      lz_mask[i] = lzb_q && (i != 0) && lead_zero;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib = value_q[4*i +: 4];
        off = blank_q[i] | lz_mask[i];
`ifdef SEVEN_SEG_SCAN_DP_EN
        dp_d = ~(dpm_q[i] & ~blank_q[i]);
`endif
      end
    end
    // Slot phase 0 is the anti-ghosting dead cycle: all anodes off
    if (div_cnt_q != '0) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_d[i] = (idx_q != IDX_W'(i));
      end
    end
`ifdef SEVEN_SEG_SCAN_DP_EN
    if (div_cnt_q == '0) dp_d = 1'b1;
`endif
    seg_d  = off ? SEG_OFF : hex_to_seg(nib);
    tick_d = (div_cnt_q == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      value_q   <= '0;
      blank_q   <= '0;
      lzb_q     <= 1'b0;
      div_cnt_q <= '0;
      idx_q     <= '0;
      seg_q     <= SEG_OFF;
      dig_q     <= '1;
      tick_q    <= 1'b0;
`ifdef SEVEN_SEG_SCAN_DP_EN
      dpm_q     <= '0;
      dp_q      <= 1'b1;
`endif
    end else begin
      value_q   <= value_d;
      blank_q   <= blank_d;
      lzb_q     <= lzb_d;
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      tick_q    <= tick_d;
`ifdef SEVEN_SEG_SCAN_DP_EN
      dpm_q     <= dpm_d;
      dp_q      <= dp_d;
`endif
    end
  end

  assign segOut   = seg_q;
  assign digitOut = dig_q;
  assign scanTick = tick_q;
`ifdef SEVEN_SEG_SCAN_DP_EN
  assign dpOut    = dp_q;
`endif

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: per-cycle expectations from an arithmetic model, checked by a separate monitor.
module tb_seven_seg_scan;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;

  logic          clk;
  logic          rst;
  logic          loadIn;
  logic [15:0]   valueIn;
  logic [3:0]    blankIn;
  logic          lzbIn;
  logic [6:0]    segOut;
  logic [3:0]    digitOut;
  logic          scanTick;
`ifdef SEVEN_SEG_SCAN_DP_EN
  logic [3:0]    dpIn;
  logic          dpOut;
`endif

  seven_seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .loadIn   (loadIn),
    .valueIn  (valueIn),
    .blankIn  (blankIn),
    .lzbIn    (lzbIn),
`ifdef SEVEN_SEG_SCAN_DP_EN
    .dpIn     (dpIn),
    .dpOut    (dpOut),
`endif
    .segOut   (segOut),
    .digitOut (digitOut),
    .scanTick (scanTick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       tick;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: cycles since reset release plus shadowed inputs
  int          k;
  logic [15:0] m_val;
  logic [3:0]  m_blk;
  logic [3:0]  m_dp;
  logic        m_lzb;
  logic [6:0]  seg_tab [16];

  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h18; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
  end

  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] b, input logic z, input logic [3:0] d);
    exp_t        e;
    int          slot;
    int          ph;
    logic [3:0]  one;
    logic [15:0] upper;
    logic        off;
    @(negedge clk);
    rst     = r;
    loadIn  = ld;
    valueIn = v;
    blankIn = b;
    lzbIn   = z;
`ifdef SEVEN_SEG_SCAN_DP_EN
    dpIn    = d;
`endif
    if (!r) begin
      e.seg = 7'h7F; e.dig = 4'hF; e.tick = 1'b0; e.dp = 1'b1;
      k = 0; m_val = '0; m_blk = '0; m_lzb = 1'b0; m_dp = '0;
    end else begin
      slot  = (k / SD) % ND;
      ph    = k % SD;
      one   = 4'b0001;
      upper = m_val >> (4 * slot);
      off   = m_blk[slot] || (m_lzb && slot > 0 && upper == 16'h0);
      e.seg  = off ? 7'h7F : seg_tab[upper[3:0]];
      e.dig  = (ph == 0) ? 4'hF : ~(one << slot);
      e.tick = (ph == SD - 1);
      e.dp   = (ph == 0 || !m_dp[slot] || m_blk[slot]);
      if (ld) begin
        m_val = v; m_blk = b; m_lzb = z; m_dp = d;
      end
      k++;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: one registered output set per clock, compared against the oldest expectation
  initial begin
    exp_t e;
    logic dp_act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
`ifdef SEVEN_SEG_SCAN_DP_EN
        dp_act = dpOut;
`else
        dp_act = e.dp;
`endif
        total++;
        if (segOut !== e.seg || digitOut !== e.dig || scanTick !== e.tick || dp_act !== e.dp) begin
          bad++;
          $display("FAIL outputs @%0t: got seg=%h dig=%b tick=%b dp=%b, want seg=%h dig=%b tick=%b dp=%b",
                   $time, segOut, digitOut, scanTick, dp_act, e.seg, e.dig, e.tick, e.dp);
        end
      end
    end
  end

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 4'h0);
  endtask

  initial begin
    logic [15:0] v;
    logic [3:0]  b;
    rst = 1'b0; loadIn = 1'b0; valueIn = '0; blankIn = '0; lzbIn = 1'b0;
`ifdef SEVEN_SEG_SCAN_DP_EN
    dpIn = '0;
`endif
    k = 0; m_val = '0; m_blk = '0; m_lzb = 1'b0; m_dp = '0;

    repeat (3) step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 16'h12AF, 4'h0, 1'b0, 4'b0010);
    run(2 * ND * SD);
    step(1'b1, 1'b1, 16'h0050, 4'h0, 1'b1, 4'b0010);
    run(ND * SD + 3);
    step(1'b1, 1'b1, 16'h0000, 4'h0, 1'b1, 4'b0010);
    run(ND * SD + 1);
    step(1'b1, 1'b1, 16'h0000, 4'b0101, 1'b0, 4'b0010);
    run(ND * SD + 2);
    step(1'b1, 1'b1, 16'h0000, 4'b0010, 1'b0, 4'b0010);
    run(ND * SD);
    // Land a load in the middle of digit 1's slot, then reset mid-slot
    step(1'b1, 1'b1, 16'h0000, 4'h0, 1'b0, 4'h0);
    while ((k % (ND * SD)) != SD + 2) run(1);
    step(1'b1, 1'b1, 16'h0030, 4'h0, 1'b0, 4'h0);
    run(3);
    step(1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 4'h0);
    run(ND * SD + 2);

    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < 4; j++)
        v[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) == 0), v, b,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
